// File: rtl/cnc_pkg.sv
// Shared definitions for the multi-axis stepper pulse generator.
// Holds register offsets, CTRL bit positions, the axis state encoding and LED constants.
// No logic; imported by cnc_axis_gen and cnc_step_gen.
package cnc_pkg;

    // Register offsets within an axis window (address bits [3:2])
    localparam logic [1:0] REG_PERIOD  = 2'd0;
    localparam logic [1:0] REG_STEPS   = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_CLRDONE = 2'd3;

    // CTRL register bits
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_DIR_BIT   = 1;
    localparam int CTRL_ABORT_BIT = 2;

    // CLRDONE data bit that redirects the mask to the position counters
    localparam int CLR_POS_BIT = 31;

    // Axis sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } axis_state_t;

    // LEDs are active-low: all dark when nothing is busy or done
    localparam logic [7:0] LED_IDLE = 8'hFF;

endpackage

// File: rtl/cnc_axis_gen.sv
// One stepper axis: DIR setup guard, then STEP pulses of PERIOD high / PERIOD low for STEPS pulses.
// Latency: STEPS commit -> DIR updated next cycle, first STEP rise DIR_SETUP cycles after that.
// Backpressure: none; register writes are accepted every cycle, later writes override earlier ones.
// Ports: LClk/rst; wr_period/wr_steps/wr_ctrl/clr_done strobes with shared wdata;
//        step/dir/enb/busy/done outputs. With CNC_POSITION_EN defined, clr_pos in and signed pos out.
module cnc_axis_gen
    import cnc_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int DIR_SETUP = 4
) (
    input  logic             LClk,
    input  logic             rst,
    input  logic             wr_period,
    input  logic             wr_steps,
    input  logic             wr_ctrl,
    input  logic             clr_done,
`ifdef CNC_POSITION_EN
    input  logic             clr_pos,
    output logic [CNT_W-1:0] pos,
`endif
    input  logic [CNT_W-1:0] wdata,
    output logic             step,
    output logic             dir,
    output logic             enb,
    output logic             busy,
    output logic             done
);

    localparam int                 SETUP_W    = $clog2(DIR_SETUP + 2);
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(DIR_SETUP);

    axis_state_t        state, state_d;
    logic [SETUP_W-1:0] setup_cnt;
    logic [CNT_W-1:0]   hp_cnt;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   period_reg;
    logic [CNT_W-1:0]   period_eff;
    logic [CNT_W-1:0]   rem_eff;
    logic               enable_reg;
    logic               dir_reg;
    logic               stop_req;
    logic               load_setup;
    logic               load_hp;
    logic               dec_rem;
    logic               set_done;

    // A zero half-period would stall the counter; run it as one cycle instead
    assign period_eff = (period_reg == '0) ? CNT_W'(1) : period_reg;

    // Clearing enable or pulsing abort stops motion without flagging completion
    assign stop_req = wr_ctrl && (!wdata[CTRL_EN_BIT] || wdata[CTRL_ABORT_BIT]);

    // A STEPS write landing on the terminal cycle takes priority over the old count
    assign rem_eff = wr_steps ? wdata : remaining;

    assign busy = (state != IDLE);
    assign enb  = enable_reg;

    always_ff @(posedge LClk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        load_setup = 1'b0;
        load_hp    = 1'b0;
        dec_rem    = 1'b0;
        set_done   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_steps) begin
                    if (wdata == '0) begin
                        set_done = 1'b1;
                    end else if (enable_reg) begin
                        state_d    = SETUP;
                        load_setup = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (setup_cnt <= SETUP_W'(1)) begin
                    if (rem_eff != '0) begin
                        state_d = HIGH;
                        load_hp = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        set_done = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (hp_cnt <= CNT_W'(1)) begin
                    state_d = LOW;
                    load_hp = 1'b1;
                    dec_rem = 1'b1;
                end
            end
            LOW: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (hp_cnt <= CNT_W'(1)) begin
                    if (rem_eff != '0) begin
                        state_d = HIGH;
                        load_hp = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        set_done = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge LClk or negedge rst) begin
        if (!rst) begin
            period_reg <= '0;
            enable_reg <= 1'b0;
            dir_reg    <= 1'b0;
            setup_cnt  <= '0;
            hp_cnt     <= '0;
            remaining  <= '0;
            dir        <= 1'b0;
            step       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (wr_period) begin
                period_reg <= wdata;
            end
            // dir_reg is only staged here; dir itself follows it at the next start
            if (wr_ctrl) begin
                enable_reg <= wdata[CTRL_EN_BIT];
                dir_reg    <= wdata[CTRL_DIR_BIT];
            end

            if (load_setup) begin
                setup_cnt <= SETUP_LOAD;
            end else if ((state == SETUP) && (setup_cnt != '0)) begin
                setup_cnt <= setup_cnt - SETUP_W'(1);
            end

            // period_reg is sampled only on reload, so mid-motion writes apply at the next half-period
            if (load_hp) begin
                hp_cnt <= period_eff;
            end else if (((state == HIGH) || (state == LOW)) && (hp_cnt != '0)) begin
                hp_cnt <= hp_cnt - CNT_W'(1);
            end

            if (wr_steps) begin
                remaining <= wdata;
            end else if (dec_rem && (remaining != '0)) begin
                remaining <= remaining - CNT_W'(1);
            end

            if (load_setup) begin
                dir <= dir_reg;
            end

            step <= (state_d == HIGH);

            if (clr_done) begin
                done <= 1'b0;
            end else if (set_done) begin
                done <= 1'b1;
            end else if (wr_steps) begin
                done <= 1'b0;
            end
        end
    end

`ifdef CNC_POSITION_EN
    localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    // Counts on each STEP rising edge; saturates at the signed limits
    always_ff @(posedge LClk or negedge rst) begin
        if (!rst) begin
            pos <= '0;
        end else if (clr_pos) begin
            pos <= '0;
        end else if ((state != HIGH) && (state_d == HIGH)) begin
            if (dir) begin
                if (pos != POS_MAX) begin
                    pos <= pos + CNT_W'(1);
                end
            end else begin
                if (pos != POS_MIN) begin
                    pos <= pos - CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/cnc_step_gen.sv
// Multi-axis stepper pulse generator behind a write-only local-bus register window.
// Latency: a write commits the cycle after LWR rises; axis registers update on the following edge.
// Backpressure: none; every completed bus write commits exactly once, invalid axis writes are dropped.
// Ports: LClk, rst (async active-low), ADS/LWR (active-low strobes), LAD address/data;
//        per-axis step_o/dir_o/enb_o/busy_o/done_o; LEDS active-low {busy[3:0],done[3:0]};
//        pos_o per-axis signed positions when CNC_POSITION_EN is defined, otherwise driven 0.
module cnc_step_gen
    import cnc_pkg::*;
#(
    parameter int N_AXES    = 3,
    parameter int CNT_W     = 32,
    parameter int DIR_SETUP = 4
) (
    input  logic                    LClk,
    input  logic                    rst,
    input  logic                    ADS,
    input  logic                    LWR,
    input  logic [31:0]             LAD,
    output logic [N_AXES-1:0]       step_o,
    output logic [N_AXES-1:0]       dir_o,
    output logic [N_AXES-1:0]       enb_o,
    output logic [N_AXES-1:0]       busy_o,
    output logic [N_AXES-1:0]       done_o,
    output logic [7:0]              LEDS,
    output logic [N_AXES*CNT_W-1:0] pos_o
);

    // Only the decoded address bits are kept
    logic [6:2]       addr_q;
    logic [31:0]      data_q;
    logic             wr_pend;
    logic             commit;
    logic             axis_ok;
    logic             wr_period;
    logic             wr_steps;
    logic             wr_ctrl;
    logic             wr_clrdone;
    logic             done_clear;
    logic [CNT_W-1:0] wdata;
    logic [3:0]       led_busy;
    logic [3:0]       led_done;

    always_ff @(posedge LClk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            wr_pend <= 1'b0;
            commit  <= 1'b0;
        end else begin
            if (!ADS) begin
                addr_q <= LAD[6:2];
            end
            if (!LWR) begin
                data_q  <= LAD;
                wr_pend <= 1'b1;
            end else if (wr_pend) begin
                wr_pend <= 1'b0;
            end
            // One pulse per write, raised once the strobe has gone away
            commit <= LWR && wr_pend;
        end
    end

    assign axis_ok    = commit && (32'(addr_q[6:4]) < 32'(N_AXES));
    assign wr_period  = axis_ok && (addr_q[3:2] == REG_PERIOD);
    assign wr_steps   = axis_ok && (addr_q[3:2] == REG_STEPS);
    assign wr_ctrl    = axis_ok && (addr_q[3:2] == REG_CTRL);
    assign wr_clrdone = axis_ok && (addr_q[3:2] == REG_CLRDONE);
    assign wdata      = CNT_W'(data_q);

`ifdef CNC_POSITION_EN
    logic pos_clear;
    assign pos_clear  = wr_clrdone && data_q[CLR_POS_BIT];
    assign done_clear = wr_clrdone && !data_q[CLR_POS_BIT];
`else
    assign done_clear = wr_clrdone;
    assign pos_o      = '0;
`endif

    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        logic hit;
        // CLRDONE is mask-driven across all axes; the others target one axis
        assign hit = (addr_q[6:4] == 3'(g));

        cnc_axis_gen #(
            .CNT_W     (CNT_W),
            .DIR_SETUP (DIR_SETUP)
        ) u_axis (
            .LClk      (LClk),
            .rst       (rst),
            .wr_period (wr_period && hit),
            .wr_steps  (wr_steps && hit),
            .wr_ctrl   (wr_ctrl && hit),
            .clr_done  (done_clear && data_q[g]),
`ifdef CNC_POSITION_EN
            .clr_pos   (pos_clear && data_q[g]),
            .pos       (pos_o[g*CNT_W +: CNT_W]),
`endif
            .wdata     (wdata),
            .step      (step_o[g]),
            .dir       (dir_o[g]),
            .enb       (enb_o[g]),
            .busy      (busy_o[g]),
            .done      (done_o[g])
        );
    end

    // LED nibbles cover axes 0..3; absent axes read as inactive
    for (genvar l = 0; l < 4; l++) begin : g_led
        if (l < N_AXES) begin : g_used
            assign led_busy[l] = busy_o[l];
            assign led_done[l] = done_o[l];
        end else begin : g_unused
            assign led_busy[l] = 1'b0;
            assign led_done[l] = 1'b0;
        end
    end

    assign LEDS = LED_IDLE ^ {led_busy, led_done};

endmodule

// File: tb/tb_cnc_step_gen.sv
// Directed bench for cnc_step_gen: bus writes, pulse timing, direction hold, stop, done and LEDs.
// Latency: inputs driven and outputs sampled on the falling edge of LClk.
// Backpressure: none; every wait is bounded and a timeout shows up as a mismatch.
module tb_cnc_step_gen;
    import cnc_pkg::*;

    localparam int NA = 3;
    localparam int CW = 32;
    localparam int DS = 4;

    logic             LClk;
    logic             rst;
    logic             ADS;
    logic             LWR;
    logic [31:0]      LAD;
    logic [NA-1:0]    step_o;
    logic [NA-1:0]    dir_o;
    logic [NA-1:0]    enb_o;
    logic [NA-1:0]    busy_o;
    logic [NA-1:0]    done_o;
    logic [7:0]       LEDS;
    logic [NA*CW-1:0] pos_o;

    int n_cmp = 0;
    int n_err = 0;

    cnc_step_gen #(
        .N_AXES    (NA),
        .CNT_W     (CW),
        .DIR_SETUP (DS)
    ) dut (
        .LClk   (LClk),
        .rst    (rst),
        .ADS    (ADS),
        .LWR    (LWR),
        .LAD    (LAD),
        .step_o (step_o),
        .dir_o  (dir_o),
        .enb_o  (enb_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .LEDS   (LEDS),
        .pos_o  (pos_o)
    );

    initial begin
        LClk = 1'b0;
        forever #5 LClk = ~LClk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input int ax, input logic [1:0] r);
        return (32'(ax) << 4) | (32'(r) << 2);
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge LClk);
        ADS = 1'b0;
        LAD = a;
        @(negedge LClk);
        ADS = 1'b1;
        LWR = 1'b0;
        LAD = d;
        @(negedge LClk);
        LWR = 1'b1;
    endtask

    function automatic logic sig_of(input int sel, input int ax);
        case (sel)
            0:       return step_o[ax];
            1:       return busy_o[ax];
            default: return dir_o[ax];
        endcase
    endfunction

    // n = falling edges until the selected signal reaches lvl, or -1 on timeout
    task automatic wait_for(input int sel, input int ax, input logic lvl, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge LClk);
            if (sig_of(sel, ax) === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_axis(input string tag, input int ax, input int steps);
        int n;
        bus_write(reg_addr(ax, REG_STEPS), 32'(steps));
        wait_for(1, ax, 1'b1, 20, n);
        wait_for(1, ax, 1'b0, 500, n);
        check_val(tag, 32'(n > 0), 1);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        ADS = 1'b1;
        LWR = 1'b1;
        LAD = '0;
        repeat (3) @(negedge LClk);
        check_val("rst_step", 32'(step_o), 0);
        check_val("rst_leds", 32'(LEDS), 32'hFF);
        rst = 1'b1;
        @(negedge LClk);
        check_val("idle_busy_done", 32'({busy_o, done_o, dir_o, enb_o}), 0);
        check_val("idle_leds", 32'(LEDS), 32'hFF);
        check_val("idle_pos", 32'(|pos_o), 0);

        // Axis 5 does not exist: nothing may change
        bus_write(reg_addr(5, REG_CTRL), 3);
        bus_write(reg_addr(5, REG_PERIOD), 2);
        bus_write(reg_addr(5, REG_STEPS), 10);
        repeat (10) @(negedge LClk);
        check_val("ax5_enb", 32'(enb_o), 0);
        check_val("ax5_busy", 32'(busy_o), 0);
        check_val("ax5_leds", 32'(LEDS), 32'hFF);

        // Axis 0: 4 pulses of 3 high / 3 low
        bus_write(reg_addr(0, REG_PERIOD), 3);
        bus_write(reg_addr(0, REG_CTRL), 1);
        repeat (2) @(negedge LClk);
        check_val("ax0_enb", 32'(enb_o), 1);
        bus_write(reg_addr(0, REG_STEPS), 4);
        // one edge for the commit pulse to appear, then DIR_SETUP+1
        wait_for(0, 0, 1'b1, 50, n);
        check_val("ax0_first_rise", 32'(n), DS + 2);
        check_val("ax0_leds_busy", 32'(LEDS), 32'hEF);
        for (int p = 0; p < 4; p++) begin
            if (p > 0) begin
                wait_for(0, 0, 1'b1, 50, n);
                check_val("ax0_low_len", 32'(n), 3);
            end
            wait_for(0, 0, 1'b0, 50, n);
            check_val("ax0_high_len", 32'(n), 3);
        end
        wait_for(1, 0, 1'b0, 50, n);
        check_val("ax0_tail_len", 32'(n), 3);
        check_val("ax0_done", 32'(done_o), 1);
        check_val("ax0_leds_done", 32'(LEDS), 32'hFE);

        // Axis 1: direction change while busy is held until the next start
        bus_write(reg_addr(1, REG_PERIOD), 5);
        bus_write(reg_addr(1, REG_CTRL), 1);
        bus_write(reg_addr(1, REG_STEPS), 20);
        wait_for(0, 1, 1'b1, 50, n);
        check_val("ax1_first_rise", 32'(n), DS + 2);
        bus_write(reg_addr(1, REG_CTRL), 3);
        repeat (3) @(negedge LClk);
        check_val("ax1_dir_held", 32'(dir_o[1]), 0);
        check_val("ax1_still_busy", 32'(busy_o[1]), 1);
        wait_for(1, 1, 1'b0, 1000, n);
        check_val("ax1_finished", 32'(n > 0), 1);
        check_val("ax1_dir_at_idle", 32'(dir_o[1]), 0);
        check_val("ax1_done", 32'(done_o[1]), 1);
        bus_write(reg_addr(1, REG_STEPS), 2);
        wait_for(2, 1, 1'b1, 20, n);
        check_val("ax1_dir_update", 32'(n), 2);
        wait_for(0, 1, 1'b1, 20, n);
        check_val("ax1_dir_setup", 32'(n), DS);
        wait_for(1, 1, 1'b0, 100, n);
        check_val("ax1_done2", 32'(done_o[1]), 1);

        // Axis 2: PERIOD 0 runs as 1, then disable mid-motion
        bus_write(reg_addr(2, REG_PERIOD), 0);
        bus_write(reg_addr(2, REG_CTRL), 1);
        bus_write(reg_addr(2, REG_STEPS), 100);
        wait_for(0, 2, 1'b1, 50, n);
        check_val("ax2_first_rise", 32'(n), DS + 2);
        wait_for(0, 2, 1'b0, 10, n);
        check_val("ax2_high_len", 32'(n), 1);
        for (int k = 1; k < 10; k++) begin
            wait_for(0, 2, 1'b1, 10, n);
            wait_for(0, 2, 1'b0, 10, n);
        end
        check_val("ax2_tenth_high", 32'(n), 1);
        bus_write(reg_addr(2, REG_CTRL), 0);
        @(negedge LClk);
        check_val("ax2_busy_at_commit", 32'(busy_o[2]), 1);
        @(negedge LClk);
        check_val("ax2_stop_busy", 32'(busy_o[2]), 0);
        check_val("ax2_stop_step", 32'(step_o[2]), 0);
        check_val("ax2_stop_done", 32'(done_o[2]), 0);
        check_val("ax2_enb_off", 32'(enb_o[2]), 0);
        repeat (5) @(negedge LClk);
        check_val("ax2_quiet", 32'({busy_o[2], step_o[2]}), 0);

        // STEPS=0 completes at once without pulsing; CLRDONE mask clears flags
        bus_write(reg_addr(0, REG_CLRDONE), 7);
        repeat (2) @(negedge LClk);
        check_val("clr_all_done", 32'(done_o), 0);
        bus_write(reg_addr(0, REG_STEPS), 0);
        @(negedge LClk);
        check_val("zero_steps_pre", 32'(done_o[0]), 0);
        @(negedge LClk);
        check_val("zero_steps_done", 32'(done_o[0]), 1);
        wait_for(0, 0, 1'b1, 10, n);
        check_val("zero_steps_no_pulse", 32'(n), 32'hFFFF_FFFF);
        bus_write(reg_addr(0, REG_CLRDONE), 7);
        repeat (2) @(negedge LClk);
        check_val("clr_done_again", 32'(done_o), 0);

`ifdef CNC_POSITION_EN
        check_val("ax1_pos", pos_o[CW +: CW], 32'hFFFF_FFEE);
        bus_write(reg_addr(0, REG_CLRDONE), 32'h8000_0001);
        repeat (2) @(negedge LClk);
        check_val("ax0_pos_zeroed", pos_o[0 +: CW], 0);
        bus_write(reg_addr(0, REG_CTRL), 3);
        run_axis("ax0_run_fwd", 0, 5);
        bus_write(reg_addr(0, REG_CTRL), 1);
        run_axis("ax0_run_rev", 0, 2);
        check_val("ax0_pos_net", pos_o[0 +: CW], 3);
        bus_write(reg_addr(0, REG_CLRDONE), 32'h8000_0001);
        repeat (2) @(negedge LClk);
        check_val("ax0_pos_cleared", pos_o[0 +: CW], 0);
        check_val("ax0_done_kept", 32'(done_o[0]), 1);
`else
        run_axis("ax0_run", 0, 2);
        check_val("pos_tied_off", 32'(|pos_o), 0);
`endif

        // Asynchronous reset during motion
        bus_write(reg_addr(1, REG_STEPS), 10);
        wait_for(0, 1, 1'b1, 50, n);
        check_val("ax1_rerun_rise", 32'(n), DS + 2);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_outputs", 32'({step_o, busy_o, done_o, enb_o}), 0);
        check_val("arst_leds", 32'(LEDS), 32'hFF);
        @(negedge LClk);
        rst = 1'b1;
        repeat (2) @(negedge LClk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
